keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scanned 4x4 matrix-keypad input block. It is the input-side counterpart of the multiplexed 7-seg
//  display path: it strobes columns, reads rows, and debounces. It delivers one 4-bit key code per
//  press to downstream logic, e.g. a counter preload or a display value on the board top level.
// PARAMETERS
//  SCAN_DIV    1000  clk cycles per column dwell (>=4); one frame = 4*SCAN_DIV cycles
//  DEBOUNCE_N  4     consecutive identical frames to accept a press or a release (1..15)
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  row        in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col        out  4  column strobes, active-low one-hot; exactly one bit low at all times
//  key_code   out  4  code of last accepted key = row_idx*4 + col_idx; held until next accept
//  key_valid  out  1  one-cycle pulse when a new press is accepted
//  key_down   out  1  level; high from accept until release is accepted
// BEHAVIOUR
//  - Reset (async assert, sync deassert inside block): col=4'b1110, key_code=0, key_valid=0,
//    key_down=0, dwell counter=0, column index=0, FSM=IDLE, frame accumulators cleared.
//  - row passes through a 2-flop synchroniser; the sync output is the only row value used.
//  - Dwell counter counts 0..SCAN_DIV-1. On the cycle where count==SCAN_DIV-1:
//    sample the sync rows for the current column, then advance col_idx 0->1->2->3->0. col rotates
//    left (1110->1101->1011->0111->1110). Sampling waits until the last dwell cycle so
//    sync + settle time of >=3 cycles is guaranteed.
//  - Frame end = sample of col 3. Frame result classes:
//    EMPTY (no low row in any column), SINGLE (exactly one row/col hit, code formed),
//    MULTI (>1 hit). MULTI is treated as EMPTY (ghosting rejection).
//  - FSM, evaluated only at frame end:
//    IDLE:     SINGLE -> PRESS_DB, cand=code, cnt=1; else stay.
//    PRESS_DB: SINGLE==cand -> cnt++; when cnt reaches DEBOUNCE_N -> HELD, key_code=cand,
//              key_valid=1 for that cycle, key_down=1. SINGLE!=cand -> cand=code, cnt=1.
//              EMPTY -> IDLE.
//    HELD:     frame==key_code -> cnt=0. Any other result (EMPTY/MULTI/other key) -> cnt++.
//              When cnt reaches DEBOUNCE_N -> IDLE, key_down=0 the same cycle.
//  - Latency: with DEBOUNCE_N=1, valid fires at the first frame end that sees the key. In general,
//    it fires at the frame end of the DEBOUNCE_N-th consecutive matching frame.
//  - A new key while HELD never produces valid; release must be accepted first.
//    At most one valid per HELD entry.
//  - Counters saturate; no wrap affects FSM. The dwell counter and col_idx wrap freely.
//  - Reset mid-press: all outputs return to reset values immediately. The FSM restarts in IDLE,
//    so a still-held key is re-debounced and re-reported.
// STRUCTURE
//  - Package keypad_pkg: state enum {IDLE,PRESS_DB,HELD,REL_DB unused-reserved}, NUM_ROWS=4,
//    NUM_COLS=4, code width 4, class enum {EMPTY,SINGLE,MULTI}.
//  - One sub-module: keypad_debounce (FSM + cnt + key_code/valid/down regs, fed by frame class
//    and code). The top level holds the synchroniser, dwell counter, column rotor and frame accumulator.
// TESTING  (bench: SCAN_DIV=4, DEBOUNCE_N=3, keypad model shorts row r to col c when pressed)
//  1 Reset, no keys -> col cycles 1110,1101,1011,0111, each held 4 clk; valid never fires;
//    key_down=0; key_code=0.
//  2 Hold r2,c1 for 5 frames -> single valid pulse at end of 3rd full frame; key_code=9; key_down=1.
//    Release -> key_down falls at end of 3rd empty frame.
//  3 Bounce: r0,c3 toggling every 6 clk for 2 frames, then stable -> no valid during bounce.
//    Then one valid with key_code=3 after 3 stable frames.
//  4 Press r1,c0 and r1,c2 together for 6 frames -> no valid (MULTI). Drop c2 -> valid, key_code=4.
//  5 Hold key 5 (accepted), then switch to key 10 without a gap -> key_down falls after 3 frames.
//    Then valid with key_code=10 after 3 further frames.
//  6 Assert rst_n=0 mid-HELD -> col=1110, key_down=0, key_code=0 asynchronously.
//    Key still held after release of reset -> re-reported after 3 frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the scanned 4x4 keypad input path.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB      // reserved, never entered
    } kp_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        SINGLE,
        MULTI
    } frame_class_t;

    // Number of asserted bits in a 4-bit row/hit vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Key code layout: row index in the upper bits, column index in the lower bits.
    function automatic logic [CODE_W-1:0] make_code(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: turns per-frame scan results into one accepted key per press.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_end,
    input  frame_class_t       frame_class,
    input  logic [CODE_W-1:0]  frame_code,
    output logic [CODE_W-1:0]  key_code,
    output logic               key_valid,
    output logic               key_down
);

    localparam logic [3:0] N_FRAMES = 4'(DEBOUNCE_N);

    kp_state_t         state, state_n;
    logic [3:0]        cnt, cnt_n, cnt_inc;
    logic [CODE_W-1:0] cand, cand_n, code_n;
    logic              valid_n;

    // State, counter, candidate and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    // Next-state logic; only a frame end can move the FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        if (frame_end) begin
            case (state)
                IDLE, PRESS_DB: begin
                    if (frame_class == SINGLE) begin
                        if (state == PRESS_DB && frame_code == cand) begin
                            cnt_n = cnt_inc;
                        end else begin
                            cand_n = frame_code;
                            cnt_n  = 4'd1;
                        end
                        // Shared accept path so DEBOUNCE_N=1 accepts straight from IDLE.
                        if (cnt_n >= N_FRAMES) begin
                            state_n = HELD;
                            code_n  = cand_n;
                            valid_n = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            state_n = PRESS_DB;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (frame_class == SINGLE && frame_code == key_code) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                    if (cnt_n >= N_FRAMES) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign key_down = (state == HELD);

endmodule

// File: rtl/keypad_scan.sv
// Scanned 4x4 matrix keypad: column strobing, row sampling, frame classification, debounce.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [1:0]        rst_sync;
    logic              rst_n_i;
    logic [3:0]        row_s1, row_s2;
    logic [DW-1:0]     dwell_cnt;
    logic              last_dwell;
    logic [1:0]        col_idx;
    logic [1:0]        acc_hits, merged_hits;
    logic [CODE_W-1:0] acc_code, merged_code;
    logic [3:0]        row_low;
    logic [2:0]        col_hits, hit_sum;
    logic [1:0]        row_enc;
    logic              frame_end;
    frame_class_t      frame_class;

    // Reset synchroniser: assert asynchronously, release on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    // Two-flop synchroniser for the asynchronous row inputs (idle rows read high).
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    assign last_dwell = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (col_idx == 2'd3);

    // Dwell counter and column rotor; both wrap freely.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
        end else if (last_dwell) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign col = ~(4'b0001 << col_idx);

    // Merge this column's sampled rows into the running frame result.
    always_comb begin
        row_low = ~row_s2;
        row_enc = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_low[r]) row_enc = 2'(r);
        end
        col_hits    = popcount4(row_low);
        hit_sum     = {1'b0, acc_hits} + col_hits;
        merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_code = (col_hits == 3'd1) ? make_code(row_enc, col_idx) : acc_code;
        case (merged_hits)
            2'd0:    frame_class = EMPTY;
            2'd1:    frame_class = SINGLE;
            default: frame_class = MULTI;
        endcase
    end

    // Frame accumulator: hit count saturates at 2, cleared after the column-3 sample.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (last_dwell) begin
            if (col_idx == 2'd3) begin
                acc_hits <= '0;
                acc_code <= '0;
            end else begin
                acc_hits <= merged_hits;
                acc_code <= merged_code;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n_i),
        .frame_end   (frame_end),
        .frame_class (frame_class),
        .frame_code  (merged_code),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_down    (key_down)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_N=3.
module tb_keypad_scan;

    localparam int SD   = 4;
    localparam int NDB  = 3;
    localparam int FRM  = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    logic [15:0] mask;          // pressed keys, bit index = row*4 + col
    bit          model_en;
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          k;             // clock edges since rst_n release
    bit          held;
    int          run_code, run_len, miss_len;
    logic [3:0]  exp_code;
    logic        exp_down, exp_valid;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_N(NDB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column strobe.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Column expected from elapsed time: two edges of reset release, then 4-cycle dwells.
    function automatic logic [3:0] exp_col();
        int j = k - 2;
        int idx = (j <= 0) ? 0 : (j / SD) % 4;
        logic [3:0] one = 4'b0001;
        return ~(one << idx);
    endfunction

    // Frame-level behaviour of the debouncer, judged on the set of pressed keys.
    task automatic frame_eval();
        int n = $countones(mask);
        int code = 0;
        bit single = (n == 1);
        for (int b = 0; b < 16; b++) if (mask[b]) code = b;
        if (!held) begin
            if (single) begin
                if (run_len > 0 && code == run_code) run_len++;
                else begin run_code = code; run_len = 1; end
                if (run_len >= NDB) begin
                    held = 1; miss_len = 0; run_len = 0;
                    exp_code = 4'(code); exp_valid = 1'b1; exp_down = 1'b1;
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (single && code == int'(exp_code)) miss_len = 0;
            else miss_len++;
            if (miss_len >= NDB) begin
                held = 0; run_len = 0; exp_down = 1'b0;
            end
        end
    endtask

    // Model advances on every clock edge; a frame ends every 16 edges after the reset delay.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0; held = 0; run_code = 0; run_len = 0; miss_len = 0;
            exp_code = '0; exp_down = 1'b0; exp_valid = 1'b0;
        end else begin
            k++;
            exp_valid = 1'b0;
            if (k - 2 > 0 && (k - 2) % FRM == 0) frame_eval();
        end
    end

    // Continuous output comparison, sampled on the falling edge.
    always begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            check("col", 32'(col), 32'(exp_col()));
            if (model_en) begin
                check("key_valid", 32'(key_valid), 32'(exp_valid));
                check("key_down",  32'(key_down),  32'(exp_down));
                check("key_code",  32'(key_code),  32'(exp_code));
            end
        end
    end

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          valids;
        logic        down;
        logic [3:0]  code;
    } step_t;

    step_t tbl [10];

    task automatic run_step(input step_t s, input int idx);
        int nv = 0;
        mask = s.mask;
        repeat (s.frames * FRM) begin
            @(negedge clk);
            if (key_valid) nv++;
        end
        check($sformatf("step%0d_valids", idx), 32'(nv), 32'(s.valids));
        check($sformatf("step%0d_down", idx), 32'(key_down), 32'(s.down));
        check($sformatf("step%0d_code", idx), 32'(key_code), 32'(s.code));
    endtask

    task automatic do_reset(input bit en_after);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_en = en_after;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);    // now aligned with the start of the first frame
    endtask

    initial begin
        int nv;
        logic [3:0] seen_code;
        rst_n = 1'b0;
        mask = '0;
        model_en = 1'b1;

        tbl[0] = '{16'h0000, 2, 0, 1'b0, 4'd0};
        tbl[1] = '{16'h0200, 5, 1, 1'b1, 4'd9};    // r2,c1
        tbl[2] = '{16'h0000, 2, 0, 1'b1, 4'd9};
        tbl[3] = '{16'h0000, 1, 0, 1'b0, 4'd9};
        tbl[4] = '{16'h0050, 6, 0, 1'b0, 4'd9};    // r1,c0 + r1,c2
        tbl[5] = '{16'h0010, 3, 1, 1'b1, 4'd4};
        tbl[6] = '{16'h0020, 3, 0, 1'b0, 4'd4};    // key 5 while 4 held
        tbl[7] = '{16'h0020, 3, 1, 1'b1, 4'd5};
        tbl[8] = '{16'h0400, 3, 0, 1'b0, 4'd5};    // key 10 while 5 held
        tbl[9] = '{16'h0400, 3, 1, 1'b1, 4'd10};

        repeat (3) @(negedge clk);
        #1;
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_down", 32'(key_down), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_step(tbl[i], i);

        // Reset while key 10 is held: outputs clear without waiting for a clock.
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_col", 32'(col), 32'h0000000E);
        check("async_down", 32'(key_down), 32'd0);
        check("async_code", 32'(key_code), 32'd0);
        check("async_valid", 32'(key_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nv = 0;
        repeat (NDB * FRM) begin
            @(negedge clk);
            if (key_valid) nv++;
        end
        check("rereport_valids", 32'(nv), 32'd1);
        check("rereport_code", 32'(key_code), 32'd10);
        check("rereport_down", 32'(key_down), 32'd1);

        // Bounce on r0,c3 for two frames, then stable.
        mask = '0;
        do_reset(1'b0);
        for (int i = 0; i < 2 * FRM; i++) begin
            if (i % 6 == 0) mask[3] = ~mask[3];
            @(negedge clk);
            check("bounce_no_valid", 32'(key_valid), 32'd0);
        end
        mask = 16'h0008;
        nv = 0;
        seen_code = '0;
        repeat (5 * FRM) begin
            @(negedge clk);
            if (key_valid) begin nv++; seen_code = key_code; end
        end
        check("bounce_valids", 32'(nv), 32'd1);
        check("bounce_code", 32'(seen_code), 32'd3);

        // Randomised key sequences checked against the model.
        mask = '0;
        do_reset(1'b1);
        for (int s = 0; s < 30; s++) begin
            int sel = int'($urandom_range(0, 9));
            int fr = int'($urandom_range(1, 4));
            logic [15:0] m = '0;
            if (sel >= 3 && sel <= 8) m[$urandom_range(0, 15)] = 1'b1;
            else if (sel == 9) begin
                m[$urandom_range(0, 15)] = 1'b1;
                m[$urandom_range(0, 15)] = 1'b1;
            end
            mask = m;
            repeat (fr * FRM) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
